twoof5_encoder_tx: RTL and testbench
====================================

Name: twoof5_encoder_tx

Overview:
- Transmit end of the 2-of-5 digit interface: accepts a BCD digit on a start strobe, checks it and encodes it to the 5-bit 2-of-5 code (CH7..CH3).
- Holds the code on parallel outputs that drive the 7-segment decoder directly, with `valido` at the same polarity the decoder expects.
- Also shifts the code out serially, CH7 first, on a timed single-wire line for a remote display board.
- Sits between the keypad/switch front end and the display/link.

Parameters:
- BIT_CYCLES, 4, clock cycles per serial bit (>=2).
- CNT_W, 8, width of the bit-period counter. BIT_CYCLES-1 must fit in CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  one-cycle request to encode and send `bcd`. Sampled only in IDLE.
- bcd  input  4  decimal digit, 0-9 valid, 10-15 invalid.
- CH7,CH6,CH5,CH4,CH3  output  1 each  held parallel 2-of-5 code.
- valido  output  1  1 = no valid code held (decoder blanks B/C/D, shows "E"); 0 = code valid.
- ser  output  1  serial line, idle 0.
- busy  output  1  1 while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.
- err  output  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (async, rst_n=0):
  - CH7..CH3=00000, valido=1, ser=0, busy=0, done=0, err=0.
  - State IDLE; counters cleared.
  - Effect is immediate, regardless of clk, including mid-frame.
- Encoding table, bcd -> CH7..CH3 (exactly two ones):
  - 0->01100, 1->11000, 2->10100, 3->10010, 4->01010
  - 5->00110, 6->10001, 7->01001, 8->00101, 9->00011
- Invalid start (IDLE, start=1, bcd>=10):
  - err=1 for the next cycle.
  - CH outputs, valido and state unchanged; no frame sent.
- Valid start (IDLE, start=1, bcd<=9):
  - On that edge: code latched into CH7..CH3 and into a 7-bit shift register as frame {1, code[4:0], 0}, i.e. start bit 1, then CH7..CH3, then stop bit 0.
  - valido=0 and busy=1 from the following cycle.
  - State -> SEND.
- SEND:
  - ser = frame MSB, held for exactly BIT_CYCLES cycles.
  - Then the frame shifts left, and the bit index increments 0..6.
  - ser changes only at bit boundaries.
  - First ser=1 appears the cycle after the start edge.
- Frame length: 7*BIT_CYCLES cycles, BIT_CYCLES=4 -> 28 cycles.
- Completion: after bit 6 (stop) has completed its BIT_CYCLES:
  - State -> IDLE; busy=0, ser=0.
  - done=1 for exactly one cycle, coincident with the first cycle of busy=0.
- start while busy: ignored (no err, no queueing, no change to held code).
- start in the same cycle done is high: accepted (state is IDLE).
- The parallel code stays held after a frame until the next valid start or reset. It never reverts to valido=1 except by reset.
- Counters:
  - Bit-period counter counts 0..BIT_CYCLES-1 and wraps.
  - Bit index is 3 bits and never exceeds 6.
- FSM states: IDLE, SEND. Only the transitions above are legal; an illegal encoding recovers to IDLE.
- All outputs are registered: no combinational path from start/bcd to any output.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> CH=00000, valido=1, ser=0, busy=0. Deassert, no start -> outputs stable for 50 cycles.
- Full sweep: for bcd=0..9, pulse start and wait for done.
  - CH7..CH3 match the table (e.g. 4->01010, 8->00101), valido=0.
  - ser sequence sampled mid-bit = 1, code bits, 0.
  - busy high exactly 28 cycles; done a single pulse.
- Invalid: after a valid 7 (01001), start with bcd=12 -> err pulses once, CH stays 01001, valido stays 0, ser stays 0, busy stays 0.
- Busy collision: start bcd=3, then start bcd=5 at cycle 10 of the frame -> ignored; frame carries 10010; CH=10010 after done.
- Back-to-back: start bcd=9 in the done cycle of the previous frame -> new frame begins next cycle with ser=1; no idle gap beyond the stop bit.
- Reset mid-frame: rst_n low at cycle 13 of frame bcd=6 -> immediately ser=0, busy=0, CH=00000, valido=1. No done pulse. Next start bcd=1 sends a clean 11000 frame.

Source files
------------

// File: rtl/twoof5_encoder_tx.sv
// Transmit end of the 2-of-5 digit link: encodes a BCD digit, holds the code on
// parallel outputs for the local decoder and shifts a timed serial frame out.
`timescale 1ns/1ps

module twoof5_encoder_tx #(
  parameter int BIT_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] bcd,
  output logic       CH7,
  output logic       CH6,
  output logic       CH5,
  output logic       CH4,
  output logic       CH3,
  output logic       valido,
  output logic       ser,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Handshake: start is a one-cycle request with no ready; it is acted on only
  // while IDLE (busy=0). A request seen while busy is dropped, never queued.
  // done pulses on the first idle cycle, so start may be raised in that cycle.

  // Two-bit codes so that any value other than the two legal ones falls back
  // to IDLE through the default branch.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SEND = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'd6;

  state_t           state;
  logic [4:0]       ch;
  logic [6:0]       shreg;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [4:0]       enc;
  logic             bcd_ok;

  function automatic logic [4:0] encode(input logic [3:0] d);
    logic [4:0] c;
    case (d)
      4'd0:    c = 5'b01100;
      4'd1:    c = 5'b11000;
      4'd2:    c = 5'b10100;
      4'd3:    c = 5'b10010;
      4'd4:    c = 5'b01010;
      4'd5:    c = 5'b00110;
      4'd6:    c = 5'b10001;
      4'd7:    c = 5'b01001;
      4'd8:    c = 5'b00101;
      4'd9:    c = 5'b00011;
      default: c = 5'b00000;
    endcase
    return c;
  endfunction

  assign enc    = encode(bcd);
  assign bcd_ok = (bcd <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch     <= 5'b00000;
      shreg  <= 7'b0000000;
      cnt    <= '0;
      idx    <= 3'd0;
      valido <= 1'b1;
      ser    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bcd_ok) begin
              ch     <= enc;
              shreg  <= {1'b1, enc, 1'b0};
              ser    <= 1'b1;
              cnt    <= '0;
              idx    <= 3'd0;
              valido <= 1'b0;
              busy   <= 1'b1;
              state  <= SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              idx   <= 3'd0;
              ser   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              // ser is loaded from the bit that becomes the new MSB
              shreg <= {shreg[5:0], 1'b0};
              ser   <= shreg[5];
              idx   <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          idx   <= 3'd0;
          ser   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign CH7 = ch[4];
  assign CH6 = ch[3];
  assign CH5 = ch[2];
  assign CH4 = ch[1];
  assign CH3 = ch[0];

endmodule

// File: tb/tb_twoof5_encoder_tx.sv
// Directed bench for twoof5_encoder_tx: table sweep, invalid digit, busy
// collision, back-to-back frames and asynchronous reset mid-frame.
`timescale 1ns/1ps

module tb_twoof5_encoder_tx;

  localparam int BIT_CYCLES = 4;
  localparam int FRAME_LEN  = 7 * BIT_CYCLES;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] bcd;
  logic       CH7, CH6, CH5, CH4, CH3;
  logic       valido, ser, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] code_tbl [10];
  logic [0:0] exp_q [$];

  twoof5_encoder_tx #(.BIT_CYCLES(BIT_CYCLES), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bcd    (bcd),
    .CH7    (CH7),
    .CH6    (CH6),
    .CH5    (CH5),
    .CH4    (CH4),
    .CH3    (CH3),
    .valido (valido),
    .ser    (ser),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ch_now();
    return {CH7, CH6, CH5, CH4, CH3};
  endfunction

  // drivers: called at a negedge, return at the negedge after the sampling edge
  task automatic pulse_start(input logic [3:0] d);
    bcd   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_frame(input logic [4:0] code);
    logic [6:0] f;
    f = {1'b1, code, 1'b0};
    for (int k = 6; k >= 0; k--) exp_q.push_back(f[k]);
  endtask

  // Walks the 28 frame cycles checking ser/busy, optionally firing a second
  // start at cycle coll_at; returns in the done cycle.
  task automatic check_frame(input logic [4:0] code, input int coll_at, input logic [3:0] coll_bcd);
    logic [0:0] cur;
    int busy_cnt;
    busy_cnt = 0;
    cur = 1'b0;
    push_frame(code);
    for (int n = 0; n < FRAME_LEN; n++) begin
      if (n % BIT_CYCLES == 0) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 16'd1, 16'd0);
        else cur = exp_q.pop_front();
      end
      check("ser_bit", {15'd0, ser}, {15'd0, cur});
      check("done_mid", {15'd0, done}, 16'd0);
      if (busy) busy_cnt++;
      if (n == coll_at) begin bcd = coll_bcd; start = 1'b1; end
      if (n == coll_at + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_len", 16'(busy_cnt), 16'(FRAME_LEN));
    check("done_pulse", {13'd0, done, busy, ser}, 16'b100);
    check("ch_held", {10'd0, ch_now(), valido}, {10'd0, code, 1'b0});
  endtask

  task automatic idle_after_done();
    @(negedge clk);
    check("done_single", {15'd0, done}, 16'd0);
  endtask

  initial begin
    code_tbl = '{5'b01100, 5'b11000, 5'b10100, 5'b10010, 5'b01010,
                 5'b00110, 5'b10001, 5'b01001, 5'b00101, 5'b00011};
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 4'd0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {10'd0, ch_now(), valido, ser, busy, done, err},
          {10'd0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_stable", {10'd0, ch_now(), valido, ser, busy, done, err},
            {10'd0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end

    // full sweep
    for (int d = 0; d < 10; d++) begin
      pulse_start(4'(d));
      check_frame(code_tbl[d], -10, 4'd0);
      idle_after_done();
    end
    check("sweep_code4", {11'd0, code_tbl[4]}, 16'b01010);

    // invalid digit after a valid 7
    pulse_start(4'd7);
    check_frame(5'b01001, -10, 4'd0);
    idle_after_done();
    pulse_start(4'd12);
    check("invalid_err", {15'd0, err}, 16'd1);
    check("invalid_hold", {10'd0, ch_now(), valido, ser, busy, 2'b00},
          {10'd0, 5'b01001, 1'b0, 1'b0, 1'b0, 2'b00});
    @(negedge clk);
    check("invalid_err_once", {13'd0, err, busy, ser}, 16'd0);

    // busy collision: second start at frame cycle 10 is ignored
    pulse_start(4'd3);
    check_frame(5'b10010, 10, 4'd5);
    check("collision_no_err", {15'd0, err}, 16'd0);
    idle_after_done();
    check("collision_idle", {10'd0, ch_now(), busy, 5'd0}, {10'd0, 5'b10010, 1'b0, 5'd0});

    // back-to-back: next start raised in the done cycle
    pulse_start(4'd2);
    check_frame(5'b10100, -10, 4'd0);
    pulse_start(4'd9);
    check("b2b_first_ser", {14'd0, ser, busy}, 16'b11);
    // pulse_start consumed cycle 0; re-enter the walk from that cycle
    exp_q.delete();
    begin
      logic [6:0] f;
      int bc;
      f  = {1'b1, 5'b00011, 1'b0};
      bc = 0;
      for (int n = 0; n < FRAME_LEN; n++) begin
        check("b2b_ser", {15'd0, ser}, {15'd0, f[6 - n / BIT_CYCLES]});
        if (busy) bc++;
        @(negedge clk);
      end
      check("b2b_busy_len", 16'(bc), 16'(FRAME_LEN));
      check("b2b_done", {13'd0, done, busy, ser}, 16'b100);
      check("b2b_code", {11'd0, ch_now()}, 16'b00011);
    end
    idle_after_done();

    // asynchronous reset in the middle of a frame for digit 6
    pulse_start(4'd6);
    repeat (12) @(negedge clk);
    check("pre_reset_busy", {15'd0, busy}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {11'd0, ch_now(), valido, ser, busy, done},
          {11'd0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {14'd0, done, busy}, 16'd0);
    end
    pulse_start(4'd1);
    check_frame(5'b11000, -10, 4'd0);
    idle_after_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
